// File: rtl/delay_line_probe_pkg.sv
// Shared types and defaults for the delay-line round-trip latency probe.
package delay_line_probe_pkg;

    localparam int PROBE_CNT_W   = 10;
    localparam int PROBE_TIMEOUT = 1023;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_LAUNCH,
        S_WAIT,
        S_CHECK,
        S_DONE,
        S_TIMEOUT
    } probe_state_t;

endpackage

// File: rtl/delay_line_probe.sv
// Launches one pulse into a register delay line and counts cycles until it
// returns; reports the latency, a timeout, or a stretched-echo error.
module delay_line_probe
    import delay_line_probe_pkg::*;
#(
    parameter int CNT_W   = PROBE_CNT_W,
    parameter int TIMEOUT = PROBE_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             echo_i,
    output logic             launch_o,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             width_err,
    output logic [CNT_W-1:0] latency
);

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    probe_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic             werr_q, werr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
            werr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            werr_q  <= werr_d;
        end
    end

    // cnt is checked against TIMEOUT before incrementing so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        werr_d  = werr_q;
        case (state_q)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (start) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                    werr_d  = 1'b0;
                end
            end
            S_FLUSH: begin
                if (!echo_i) begin
                    state_d = S_LAUNCH;
                    cnt_d   = '0;
                end else if (cnt_q == TO_VAL) begin
                    state_d = S_TIMEOUT;
                    lat_d   = '1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_LAUNCH: begin
                if (echo_i) begin
                    lat_d   = '0;
                    state_d = S_CHECK;
                end else begin
                    cnt_d   = ONE;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (echo_i) begin
                    lat_d   = cnt_q;
                    state_d = S_CHECK;
                end else if (cnt_q == TO_VAL) begin
                    state_d = S_TIMEOUT;
                    lat_d   = '1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_CHECK: begin
                // A pulse still high one cycle after capture was stretched.
                if (echo_i) werr_d = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign launch_o  = (state_q == S_LAUNCH);
    assign busy      = (state_q == S_FLUSH) || (state_q == S_LAUNCH) ||
                       (state_q == S_WAIT)  || (state_q == S_CHECK);
    assign done      = (state_q == S_DONE);
    assign timeout   = (state_q == S_TIMEOUT);
    assign width_err = werr_q;
    assign latency   = lat_q;

endmodule

// File: tb/tb_delay_line_probe.sv
// Directed bench for delay_line_probe: N-stage line model, procedural
// reference model compared every cycle, plus literal result checks.
module tb_delay_line_probe;

    localparam int TMO = 1023;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       echo;
    logic       launch_o, busy, done, timeout, width_err;
    logic [9:0] latency;

    delay_line_probe #(.CNT_W(10), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .echo_i    (echo),
        .launch_o  (launch_o),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .width_err (width_err),
        .latency   (latency)
    );

    always #5 clk = ~clk;

    // Delay line: N flops, optional stretch to 2 cycles, or stuck modes.
    int           n_stage = 480;
    int           mode    = 0;   // 0 line, 1 stuck 0, 2 stuck 1
    bit           stretch = 1'b0;
    logic [1023:0] hist;

    always @(posedge clk) begin
        if (!rst_n) hist <= '0;
        else        hist <= {hist[1022:0], launch_o};
    end

    always_comb begin
        case (mode)
            1:       echo = 1'b0;
            2:       echo = 1'b1;
            default: echo = (n_stage == 0) ? launch_o
                          : (hist[n_stage-1] | (stretch & hist[n_stage]));
        endcase
    end

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int n_launch = 0;
    int launch_cyc = 0;
    int end_cyc = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (launch_o === 1'b1) begin
            n_launch   = n_launch + 1;
            launch_cyc = cyc_n;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Reference model: walks one measurement procedurally, one clock edge
    // per step, publishing what the outputs must be after that edge.
    logic       m_busy, m_done, m_to, m_launch, m_werr;
    logic [9:0] m_lat;
    bit         ms, me, mr;

    task automatic edge_step();
        @(posedge clk);
        ms = (start === 1'b1);
        me = (echo === 1'b1);
        mr = (rst_n !== 1'b1);
        if (mr) begin
            m_busy = 0; m_done = 0; m_to = 0; m_launch = 0; m_werr = 0; m_lat = '0;
        end
    endtask

    task automatic give_up();
        m_busy = 0; m_to = 1; m_lat = '1;
    endtask

    task automatic measure();
        int n;
        m_busy = 1; m_done = 0; m_to = 0; m_werr = 0;
        n = 0;
        forever begin
            edge_step(); if (mr) return;
            if (!me) break;
            if (n == TMO) begin give_up(); return; end
            n++;
        end
        m_launch = 1;
        edge_step(); if (mr) return;
        m_launch = 0;
        n = 0;
        if (!me) begin
            n = 1;
            forever begin
                edge_step(); if (mr) return;
                if (me) break;
                if (n == TMO) begin give_up(); return; end
                n++;
            end
        end
        m_lat = 10'(n);
        edge_step(); if (mr) return;
        m_werr = me; m_busy = 0; m_done = 1;
    endtask

    initial begin : model
        m_busy = 0; m_done = 0; m_to = 0; m_launch = 0; m_werr = 0; m_lat = '0;
        forever begin
            edge_step();
            if (!mr && ms) measure();
        end
    end

    always @(negedge clk) begin
        chk("busy",      int'(busy),      int'(m_busy));
        chk("done",      int'(done),      int'(m_done));
        chk("timeout",   int'(timeout),   int'(m_to));
        chk("launch_o",  int'(launch_o),  int'(m_launch));
        chk("width_err", int'(width_err), int'(m_werr));
        chk("latency",   int'(latency),   int'(m_lat));
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int i = 0;
        while (!(done === 1'b1 || timeout === 1'b1) && i < 2000) begin
            @(negedge clk);
            i++;
        end
        end_cyc = cyc_n;
        if (i >= 2000) chk({tag, "_finish_bound"}, 0, 1);
    endtask

    initial begin : stim
        int nl;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_latency", int'(latency), 0);
        chk("rst_launch", int'(launch_o), 0);
        rst_n = 1'b1;
        while (cyc_n < 10) @(negedge clk);

        // N=480 line
        nl = n_launch;
        pulse_start();
        wait_end("n480");
        chk("n480_done", int'(done), 1);
        chk("n480_latency", int'(latency), 480);
        chk("n480_werr", int'(width_err), 0);
        chk("n480_timeout", int'(timeout), 0);
        chk("n480_launch_cycles", n_launch - nl, 1);

        // zero-stage passthrough
        n_stage = 0;
        @(negedge clk);
        pulse_start();
        wait_end("n0");
        chk("n0_done", int'(done), 1);
        chk("n0_latency", int'(latency), 0);
        chk("n0_done_delay", end_cyc - launch_cyc, 2);

        // echo stuck low
        mode = 1;
        pulse_start();
        wait_end("tie0");
        chk("tie0_timeout", int'(timeout), 1);
        chk("tie0_done", int'(done), 0);
        chk("tie0_latency", int'(latency), 1023);
        chk("tie0_delay", end_cyc - launch_cyc, 1024);

        // echo stuck high: never leaves FLUSH
        mode = 2;
        nl = n_launch;
        pulse_start();
        wait_end("tie1");
        chk("tie1_timeout", int'(timeout), 1);
        chk("tie1_latency", int'(latency), 1023);
        chk("tie1_no_launch", n_launch - nl, 0);

        // 2-cycle echo on a 5-stage line
        mode = 0; n_stage = 5; stretch = 1'b1;
        @(negedge clk);
        pulse_start();
        wait_end("wide");
        chk("wide_done", int'(done), 1);
        chk("wide_latency", int'(latency), 5);
        chk("wide_werr", int'(width_err), 1);

        // reset during WAIT at cnt=200, then a clean re-measure
        stretch = 1'b0; n_stage = 480;
        @(negedge clk);
        nl = n_launch;
        pulse_start();
        for (int i = 0; i < 50 && n_launch == nl; i++) @(negedge clk);
        chk("rstw_launched", n_launch - nl, 1);
        for (int i = 0; i < 400 && cyc_n < launch_cyc + 200; i++) @(negedge clk);
        chk("rstw_in_wait", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstw_busy", int'(busy), 0);
        chk("rstw_done", int'(done), 0);
        chk("rstw_latency", int'(latency), 0);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        wait_end("rerun");
        chk("rerun_latency", int'(latency), 480);
        chk("rerun_done", int'(done), 1);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_line_probe.md
Name: delay_line_probe

Overview:
Round-trip latency measurer for an on-chip register delay line. Launches a single-cycle pulse into the line's input and counts clock cycles until the pulse emerges at the line's output. Reports the count, or a timeout or error flag. Sits beside the shift-register delay chain in the tile top level; launch_o drives the chain input, and the chain's last stage drives echo_i.

Parameters:
CNT_W, 10, width of latency counter and result
TIMEOUT, 1023, cycles counted without echo before aborting (must be <= 2^CNT_W-1)

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
start  input  1  request a measurement; sampled each cycle, ignored while busy
echo_i  input  1  delay-line output
launch_o  output  1  registered pulse into delay-line input
busy  output  1  high in FLUSH, LAUNCH, WAIT, CHECK
done  output  1  high in DONE; held until next start
timeout  output  1  high in TIMEOUT; held until next start
width_err  output  1  echo lasted >1 cycle; valid with done
latency  output  CNT_W  measured cycles; held until next start

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE. All outputs 0, cnt=0. Reset mid-measurement aborts immediately; launch_o=0 the next cycle.
- States: IDLE, FLUSH, LAUNCH, WAIT, CHECK, DONE, TIMEOUT. All outputs are registered or decoded from the state register; no combinational path from echo_i to any output.
- IDLE/DONE/TIMEOUT + start=1 -> FLUSH. On this transition cnt:=0 and done/timeout/width_err:=0. latency is retained until the new result is written.
- FLUSH: waits for the line to drain.
  - echo_i=0 -> LAUNCH, cnt:=0.
  - echo_i=1 -> cnt++; when cnt reaches TIMEOUT -> TIMEOUT.
- LAUNCH: exactly one cycle, with launch_o=1 in this cycle only (call it cycle L, cnt=0).
  - If echo_i=1 in L (zero-stage passthrough), latency:=0 -> CHECK.
  - Otherwise cnt:=1 -> WAIT.
- WAIT: cnt increments each cycle, so cnt=k in cycle L+k.
  - echo_i=1 -> latency:=cnt -> CHECK. An N-flop line therefore reports exactly N.
  - echo_i=0 and cnt==TIMEOUT -> TIMEOUT.
- CHECK: one cycle. If echo_i=1, width_err:=1. Go to DONE either way.
- TIMEOUT: latency:=all ones, timeout=1, done=0.
- Echo pulses arriving in DONE, TIMEOUT or IDLE are ignored.
- start held high re-triggers from DONE/TIMEOUT one cycle after entry, giving back-to-back measurements.
- cnt never wraps; it is compared against TIMEOUT before incrementing.
- done and timeout are mutually exclusive. busy=0 whenever done or timeout is 1.

Decomposition:
- Shared package holds:
  - the state enum probe_state_t (7 states, 3-bit encoding);
  - default constants PROBE_CNT_W=10 and PROBE_TIMEOUT=1023.
- No sub-module required; counter and FSM live in one module.
- Bench supplies a parameterised N-stage shift-register model of the delay line, with synchronous active-low reset.

Test Plan:
- N=480 line, pulse start at cycle 10 -> launch_o high for exactly 1 cycle; done=1, latency=480, width_err=0, timeout=0.
- N=0 (echo_i=launch_o) -> latency=0 and done=1, two cycles after LAUNCH.
- echo_i tied 0 -> timeout=1 after 1023 WAIT cycles; latency=1023; done=0.
- echo_i stuck 1 -> stays in FLUSH; timeout=1 after 1023 cycles; launch_o never asserts.
- Line model stretches the pulse to 2 cycles with N=5 -> latency=5, width_err=1, done=1.
- rst_n=0 during WAIT at cnt=200 -> next cycle busy=0, done=0, latency=0; a fresh start with N=480 then returns 480.
